// File: rtl/fht_mix_seq_if.sv
// Handshake and bank-read bus between the FHT controller, the input-mix
// sequencer and the mix block.
interface fht_mix_seq_if #(
   parameter int A_BIT   = 8,
   parameter int SEC_BIT = 9,
   parameter int STG_BIT = 4
);
   logic               iSTART;
   logic               iHOLD;
   logic               oRD_EN;
   logic [A_BIT-1:0]   oRD_ADDR;
   logic               oST_ZERO;
   logic [SEC_BIT-1:0] oSECTOR;
   logic               oMIX_EN;
   logic               oVALID;
   logic [STG_BIT-1:0] oSTAGE;
   logic               oBUSY;
   logic               oDONE;

   modport master (
      output iSTART, iHOLD,
      input  oRD_EN, oRD_ADDR, oST_ZERO, oSECTOR, oMIX_EN, oVALID,
             oSTAGE, oBUSY, oDONE
   );

   modport slave (
      input  iSTART, iHOLD,
      output oRD_EN, oRD_ADDR, oST_ZERO, oSECTOR, oMIX_EN, oVALID,
             oSTAGE, oBUSY, oDONE
   );
endinterface

// File: rtl/fht_mix_seq.sv
// FHT input-mix sequencer: walks stages and bank addresses, drives the
// 4-bank RAM read port and aligns mix controls/valid with the read data.
module fht_mix_seq #(
   parameter int A_BIT    = 8,
   parameter int SEC_BIT  = 9,
   parameter int STG_BIT  = 4,
   parameter int NUM_STG  = 10,
   parameter int PIPE_LAT = 6
) (
   input  logic         iCLK,
   input  logic         iRESET,
   fht_mix_seq_if.slave bus
);

   localparam int                 SW        = (A_BIT > SEC_BIT) ? A_BIT : SEC_BIT;
   localparam logic [A_BIT-1:0]   ADDR_LAST = '1;
   localparam logic [STG_BIT-1:0] STG_LAST  = STG_BIT'(NUM_STG - 1);
   localparam logic [7:0]         DRN_LAST  = 8'(PIPE_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [A_BIT-1:0]   addr, addr_nxt;
   logic [7:0]         drn_cnt, drn_nxt;
   logic [STG_BIT-1:0] stage, stage_nxt;
   logic               issue;
   logic [A_BIT-1:0]   issue_addr;

   logic               rd_en_q;
   logic [A_BIT-1:0]   rd_addr_q;
   logic               busy_q;
   logic               done_q;
   logic               mix_en_q;
   logic               valid_q;
   logic               st_zero_q;
   logic [SEC_BIT-1:0] sector_q;
   logic [SEC_BIT-1:0] sector_c;
   logic [SW-1:0]      addr_ext;

   logic last_read;
   logic drn_end;

   assign last_read = rd_en_q && (rd_addr_q == ADDR_LAST);
   assign drn_end   = (drn_cnt == DRN_LAST);

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.iSTART) state_nxt = S_READ;
         S_READ:  if (last_read)  state_nxt = S_DRAIN;
         S_DRAIN: if (drn_end)    state_nxt = (stage == STG_LAST) ? S_DONE : S_READ;
         S_DONE:                  state_nxt = S_IDLE;
         default:                 state_nxt = S_IDLE;
      endcase
   end

   // addr is the next address to issue; rd_addr_q is the one on the bus.
   // iHOLD is only sampled while in READ, so the first read of a stage is
   // always issued straight out of IDLE or DRAIN.
   always_comb begin
      issue      = 1'b0;
      issue_addr = addr;
      addr_nxt   = addr;
      drn_nxt    = drn_cnt;
      stage_nxt  = stage;
      case (state)
         S_IDLE: begin
            if (bus.iSTART) begin
               issue      = 1'b1;
               issue_addr = '0;
               addr_nxt   = A_BIT'(1);
               stage_nxt  = '0;
            end
         end
         S_READ: begin
            if (last_read) begin
               addr_nxt = '0;
               drn_nxt  = '0;
            end else if (!bus.iHOLD) begin
               issue      = 1'b1;
               issue_addr = addr;
               if (addr != ADDR_LAST) addr_nxt = addr + 1'b1;
            end
         end
         S_DRAIN: begin
            if (drn_end) begin
               drn_nxt = '0;
               if (stage != STG_LAST) begin
                  stage_nxt  = stage + 1'b1;
                  issue      = 1'b1;
                  issue_addr = '0;
                  addr_nxt   = A_BIT'(1);
               end
            end else begin
               drn_nxt = drn_cnt + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign addr_ext = SW'(rd_addr_q);
   assign sector_c = SEC_BIT'(addr_ext >> stage);

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         addr      <= '0;
         drn_cnt   <= '0;
         stage     <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         mix_en_q  <= 1'b0;
         valid_q   <= 1'b0;
         st_zero_q <= 1'b0;
         sector_q  <= '0;
      end else begin
         addr    <= addr_nxt;
         drn_cnt <= drn_nxt;
         stage   <= stage_nxt;
         rd_en_q <= issue;
         if (issue) rd_addr_q <= issue_addr;
         busy_q   <= (state_nxt != S_IDLE);
         done_q   <= (state_nxt == S_DONE);
         mix_en_q <= rd_en_q;
         valid_q  <= mix_en_q;
         if (rd_en_q) begin
            st_zero_q <= (stage == '0);
            sector_q  <= sector_c;
         end
      end
   end

   assign bus.oRD_EN   = rd_en_q;
   assign bus.oRD_ADDR = rd_addr_q;
   assign bus.oST_ZERO = st_zero_q;
   assign bus.oSECTOR  = sector_q;
   assign bus.oMIX_EN  = mix_en_q;
   assign bus.oVALID   = valid_q;
   assign bus.oSTAGE   = stage;
   assign bus.oBUSY    = busy_q;
   assign bus.oDONE    = done_q;

endmodule

// File: tb/tb_fht_mix_seq.sv
// Randomized bench for fht_mix_seq: small configuration against a
// cycle-level reference model, default configuration against totals.
module tb_fht_mix_seq;

   localparam int A     = 3;
   localparam int SECB  = 9;
   localparam int STGB  = 4;
   localparam int NSTG  = 3;
   localparam int PL    = 4;
   localparam int N     = 1 << A;
   localparam int STCYC = N + PL;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic rstb_n = 1'b0;

   always #5 clk = ~clk;

   fht_mix_seq_if #(.A_BIT(A), .SEC_BIT(SECB), .STG_BIT(STGB)) s ();
   fht_mix_seq_if #(.A_BIT(8), .SEC_BIT(9), .STG_BIT(4)) b ();

   fht_mix_seq #(
      .A_BIT(A), .SEC_BIT(SECB), .STG_BIT(STGB), .NUM_STG(NSTG), .PIPE_LAT(PL)
   ) dut_s (
      .iCLK(clk), .iRESET(rst_n), .bus(s)
   );

   fht_mix_seq dut_b (
      .iCLK(clk), .iRESET(rstb_n), .bus(b)
   );

   int n_chk = 0;
   int n_err = 0;

   // reference model: progress through the transform plus expected outputs
   int m_busy, m_stage, m_next, m_drain;
   int e_rd_en, e_rd_addr, e_stage, e_busy, e_done;
   int e_mix, e_zero, e_sector, e_valid;

   // observations of the small DUT
   int  ncyc = 0, rise_cyc = 0, done_cyc = 0, ndone = 0, nvalid = 0;
   bit  busy_q = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_stage = 0; m_next = 0; m_drain = 0;
      e_rd_en = 0; e_rd_addr = 0; e_stage = 0; e_busy = 0; e_done = 0;
      e_mix = 0; e_zero = 0; e_sector = 0; e_valid = 0;
   endtask

   // Advance one clock edge given the inputs sampled at that edge.
   task automatic model_step(input bit start, input bit hold);
      int issue;
      e_valid = e_mix;
      e_mix   = e_rd_en;
      if (e_rd_en != 0) begin
         e_zero   = (e_stage == 0) ? 1 : 0;
         e_sector = (e_rd_addr >> e_stage) & ((1 << SECB) - 1);
      end
      issue = -1;
      if (e_done != 0) begin
         e_done = 0;
         m_busy = 0;
      end else if (m_busy == 0) begin
         if (start) begin
            m_busy = 1; m_stage = 0; issue = 0;
         end
      end else if (m_drain > 0) begin
         if (m_drain > 1) m_drain--;
         else begin
            m_drain = 0;
            if (m_stage == NSTG - 1) e_done = 1;
            else begin
               m_stage++; issue = 0;
            end
         end
      end else if (m_next == N) begin
         m_drain = PL;
      end else if (!hold) begin
         issue = m_next;
      end
      if (issue >= 0) begin
         e_rd_en = 1; e_rd_addr = issue; m_next = issue + 1;
      end else begin
         e_rd_en = 0;
      end
      e_busy  = m_busy;
      e_stage = m_stage;
   endtask

   task automatic compare();
      chk("rd_en",   s.oRD_EN,   e_rd_en);
      chk("rd_addr", s.oRD_ADDR, e_rd_addr);
      chk("stage",   s.oSTAGE,   e_stage);
      chk("busy",    s.oBUSY,    e_busy);
      chk("done",    s.oDONE,    e_done);
      chk("mix_en",  s.oMIX_EN,  e_mix);
      chk("st_zero", s.oST_ZERO, e_zero);
      chk("sector",  s.oSECTOR,  e_sector);
      chk("valid",   s.oVALID,   e_valid);
   endtask

   task automatic cyc(input bit start, input bit hold);
      @(negedge clk);
      ncyc++;
      compare();
      if (s.oBUSY === 1'b1 && !busy_q) rise_cyc = ncyc;
      if (s.oDONE === 1'b1) begin done_cyc = ncyc; ndone++; end
      if (s.oVALID === 1'b1) nvalid++;
      busy_q = (s.oBUSY === 1'b1);
      s.iSTART = start;
      s.iHOLD  = hold;
      if (rst_n) model_step(start, hold);
      else       model_reset();
   endtask

   // mode 0: plain, 1: directed stall, 2: stray starts, 3: random
   task automatic run(input int mode);
      int d0, v0, stalls, h_cnt, k;
      bit st, h;
      d0 = ndone; v0 = nvalid; stalls = 0; h_cnt = 0;
      cyc(1'b1, 1'b0);
      for (k = 0; k < 1000 && m_busy != 0; k++) begin
         st = 1'b0; h = 1'b0;
         case (mode)
            1: begin
               if (m_stage == 1 && m_drain == 0 && m_next == 5 && h_cnt < 3) begin
                  h = 1'b1; h_cnt++;
               end
               if (m_stage == 0 && m_drain > 0) h = 1'b1;
            end
            2: st = (m_stage == 1 && m_next == 2 && m_drain == 0) || (e_done != 0);
            3: begin
               h  = ($urandom_range(0, 3) == 0);
               st = ($urandom_range(0, 9) == 0);
            end
            default: ;
         endcase
         if (h && m_busy != 0 && e_done == 0 && m_drain == 0 && m_next < N) stalls++;
         cyc(st, h);
      end
      repeat (3) cyc(1'b0, 1'b0);
      chk("busy_end",   s.oBUSY, 0);
      chk("done_cnt",   ndone - d0, 1);
      chk("done_delay", done_cyc - rise_cyc, NSTG * STCYC + stalls);
      chk("valid_cnt",  nvalid - v0, NSTG * N);
   endtask

   initial begin
      int d0, k, brise, bdone, bvalid, bcyc;
      s.iSTART = 1'b0; s.iHOLD = 1'b0;
      b.iSTART = 1'b0; b.iHOLD = 1'b0;
      model_reset();
      repeat (2) cyc(1'b0, 1'b0);
      rst_n  = 1'b1;
      rstb_n = 1'b1;
      repeat (2) cyc(1'b0, 1'b0);

      run(0);
      run(1);
      run(2);
      run(0);
      repeat (3) run(3);

      // asynchronous abort at stage 1, addr 4
      cyc(1'b1, 1'b0);
      for (k = 0; k < 200 && !(e_stage == 1 && e_rd_en == 1 && e_rd_addr == 4); k++)
         cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      d0 = ndone;
      rst_n = 1'b0;
      #1;
      chk("rst_rd_en",   s.oRD_EN,   0);
      chk("rst_rd_addr", s.oRD_ADDR, 0);
      chk("rst_stage",   s.oSTAGE,   0);
      chk("rst_busy",    s.oBUSY,    0);
      chk("rst_mix_en",  s.oMIX_EN,  0);
      chk("rst_valid",   s.oVALID,   0);
      chk("rst_sector",  s.oSECTOR,  0);
      chk("rst_st_zero", s.oST_ZERO, 0);
      model_reset();
      cyc(1'b0, 1'b0);
      rst_n = 1'b1;
      repeat (4) cyc(1'b0, 1'b0);
      chk("abort_no_done", ndone - d0, 0);
      run(0);

      // default configuration
      @(negedge clk);
      b.iSTART = 1'b1;
      brise = -1; bdone = -1; bvalid = 0; bcyc = 0;
      for (k = 0; k < 4000 && bdone < 0; k++) begin
         @(negedge clk);
         b.iSTART = 1'b0;
         bcyc++;
         if (brise < 0 && b.oBUSY === 1'b1) begin
            brise = bcyc;
            chk("big_first_rd", {b.oRD_EN, b.oRD_ADDR}, {1'b1, 8'd0});
         end
         if (b.oVALID === 1'b1) bvalid++;
         if (b.oDONE === 1'b1) bdone = bcyc;
      end
      chk("big_done_delay", bdone - brise, 2620);
      chk("big_valid_cnt",  bvalid, 2560);
      @(negedge clk);
      chk("big_busy_end", b.oBUSY, 0);
      chk("big_done_end", b.oDONE, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
